// File: rtl/mixer_mc.sv
// Time-multiplexed NCH-channel + beeper/tape mixer driving first-order delta-sigma 1-bit DACs.
// Optional build macro MIXER_DITHER_EN adds 2-bit LFSR dither ahead of both modulators.
module mixer_mc #(
  parameter int NCH          = 4,
  parameter int SW           = 8,
  parameter int OUT_W        = 10,
  parameter int BEEPER_LVL   = 128,
  parameter int TAPE_OUT_LVL = 32,
  parameter int TAPE_IN_LVL  = 16
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              mute,
  input  logic              beeper,
  input  logic              tape_out,
  input  logic              tape_in,
  input  logic [NCH*SW-1:0] ch_data,
  input  logic [2*NCH-1:0]  ch_gain,
  input  logic [2*NCH-1:0]  ch_pan,
  output logic [OUT_W-1:0]  sample_l,
  output logic [OUT_W-1:0]  sample_r,
  output logic              sample_strobe,
  output logic              dac_l,
  output logic              dac_r
);
  localparam int SLW = $clog2(NCH + 1);
  localparam int AW  = SW + $clog2(NCH + 2) + 1;
  // Clamp arithmetic needs at least one bit above OUT_W to see the overflow.
  localparam int CW  = (AW > OUT_W) ? AW : OUT_W + 1;
  localparam logic [SLW-1:0] LAST = SLW'(NCH);
  localparam logic [CW-1:0]  MAXV = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [SLW-1:0]   slot_q, slot_d;
  logic [AW-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic             strobe_q, strobe_d;
  logic [OUT_W:0]   dsm_l_q, dsm_l_d, dsm_r_q, dsm_r_d;
  logic [OUT_W-1:0] mod_l, mod_r;

  logic             last;
  logic [SW-1:0]    ch_sel;
  logic [1:0]       gain_sel, pan_sel;
  logic [AW-1:0]    ch_c, fx_c, add_l, add_r;
  logic [CW-1:0]    sum_l, sum_r;

  function automatic logic [OUT_W-1:0] clamp(input logic [CW-1:0] v);
    return (v > MAXV) ? {OUT_W{1'b1}} : v[OUT_W-1:0];
  endfunction

  assign last = (slot_q == LAST);

  always_comb begin
    ch_sel   = '0;
    gain_sel = '0;
    pan_sel  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (slot_q == SLW'(i)) begin
        ch_sel   = ch_data[i*SW +: SW];
        gain_sel = ch_gain[2*i +: 2];
        pan_sel  = ch_pan[2*i +: 2];
      end
    end
  end

  always_comb begin
    case (gain_sel)
      2'd3:    ch_c = AW'(ch_sel);
      2'd2:    ch_c = AW'(ch_sel >> 1);
      2'd1:    ch_c = AW'(ch_sel >> 2);
      default: ch_c = '0;
    endcase
    fx_c = (beeper   ? AW'(BEEPER_LVL)   : '0)
         + (tape_out ? AW'(TAPE_OUT_LVL) : '0)
         + (tape_in  ? AW'(TAPE_IN_LVL)  : '0);
    add_l = '0;
    add_r = '0;
    if (!mute) begin
      if (last) begin
        add_l = fx_c;
        add_r = fx_c;
      end else begin
        add_l = pan_sel[0] ? ch_c : '0;
        add_r = pan_sel[1] ? ch_c : '0;
      end
    end
    sum_l = CW'(acc_l_q) + CW'(add_l);
    sum_r = CW'(acc_r_q) + CW'(add_r);
  end

  always_comb begin
    slot_d     = last ? '0 : slot_q + SLW'(1);
    acc_l_d    = last ? '0 : sum_l[AW-1:0];
    acc_r_d    = last ? '0 : sum_r[AW-1:0];
    sample_l_d = last ? clamp(sum_l) : sample_l_q;
    sample_r_d = last ? clamp(sum_r) : sample_r_q;
    strobe_d   = last;
  end

`ifdef MIXER_DITHER_EN
  logic [14:0] lfsr_q, lfsr_d;

  // x^15 + x^14 + 1, Fibonacci form
  assign lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};

  always_comb begin
    mod_l = clamp(CW'(sample_l_q) + CW'(lfsr_q[1:0]));
    mod_r = clamp(CW'(sample_r_q) + CW'(lfsr_q[1:0]));
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) lfsr_q <= 15'h0001;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign mod_l = sample_l_q;
  assign mod_r = sample_r_q;
`endif

  // Carry out of the OUT_W-bit phase accumulator is the DAC bit.
  assign dsm_l_d = {1'b0, dsm_l_q[OUT_W-1:0]} + {1'b0, mod_l};
  assign dsm_r_d = {1'b0, dsm_r_q[OUT_W-1:0]} + {1'b0, mod_r};

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      slot_q     <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      strobe_q   <= 1'b0;
      dsm_l_q    <= '0;
      dsm_r_q    <= '0;
    end else begin
      slot_q     <= slot_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      strobe_q   <= strobe_d;
      dsm_l_q    <= dsm_l_d;
      dsm_r_q    <= dsm_r_d;
    end
  end

  assign sample_l      = sample_l_q;
  assign sample_r      = sample_r_q;
  assign sample_strobe = strobe_q;
  assign dac_l         = dsm_l_q[OUT_W];
  assign dac_r         = dsm_r_q[OUT_W];
endmodule

// File: tb/tb_mixer_mc.sv
// Randomized self-checking bench for mixer_mc against a frame-level arithmetic model.
module tb_mixer_mc;
  localparam int NCH   = 4;
  localparam int SW    = 8;
  localparam int OUT_W = 10;
  localparam int BEEP  = 128;
  localparam int TOUT  = 32;
  localparam int TIN   = 16;
  localparam int MAXV  = (1 << OUT_W) - 1;

  logic              clk28 = 1'b0;
  logic              rst_n = 1'b0;
  logic              mute = 1'b0, beeper = 1'b0, tape_out = 1'b0, tape_in = 1'b0;
  logic [NCH*SW-1:0] ch_data = '0;
  logic [2*NCH-1:0]  ch_gain = '0;
  logic [2*NCH-1:0]  ch_pan = '0;
  logic [OUT_W-1:0]  sample_l, sample_r;
  logic              sample_strobe, dac_l, dac_r;

  int errors = 0;
  int checks = 0;

  int data_m[NCH];
  int gain_m[NCH];
  int pan_m[NCH];
  bit beep_m, tout_m, tin_m, mute_m;

  mixer_mc #(
    .NCH(NCH), .SW(SW), .OUT_W(OUT_W),
    .BEEPER_LVL(BEEP), .TAPE_OUT_LVL(TOUT), .TAPE_IN_LVL(TIN)
  ) dut (
    .clk28(clk28), .rst_n(rst_n), .mute(mute), .beeper(beeper),
    .tape_out(tape_out), .tape_in(tape_in), .ch_data(ch_data),
    .ch_gain(ch_gain), .ch_pan(ch_pan), .sample_l(sample_l),
    .sample_r(sample_r), .sample_strobe(sample_strobe),
    .dac_l(dac_l), .dac_r(dac_r)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level model: each channel's scaled value, summed per side, plus fixed levels, clamped.
  function automatic int contrib(int i);
    case (gain_m[i])
      3:       return data_m[i];
      2:       return data_m[i] / 2;
      1:       return data_m[i] / 4;
      default: return 0;
    endcase
  endfunction

  function automatic int expect_side(int side);
    int s;
    s = 0;
    if (mute_m) return 0;
    for (int i = 0; i < NCH; i++)
      if (((pan_m[i] >> side) & 1) != 0) s += contrib(i);
    s += (beep_m ? BEEP : 0) + (tout_m ? TOUT : 0) + (tin_m ? TIN : 0);
    return (s > MAXV) ? MAXV : s;
  endfunction

  task automatic set_all(input int d, input int g, input int p);
    for (int i = 0; i < NCH; i++) begin
      data_m[i] = d;
      gain_m[i] = g;
      pan_m[i]  = p;
    end
    beep_m = 0; tout_m = 0; tin_m = 0; mute_m = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      ch_data[i*SW +: SW] = SW'(data_m[i]);
      ch_gain[2*i +: 2]   = 2'(gain_m[i]);
      ch_pan[2*i +: 2]    = 2'(pan_m[i]);
    end
    beeper   = beep_m;
    tape_out = tout_m;
    tape_in  = tin_m;
    mute     = mute_m;
  endtask

  // Returns at a falling edge where the strobe is high, i.e. the next rising edge is slot 0.
  task automatic wait_strobe();
    for (int i = 0; i < 4*(NCH+1); i++) begin
      @(negedge clk28);
      if (sample_strobe) return;
    end
    chk("strobe_seen", sample_strobe, 1);
  endtask

  task automatic edges_to_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 3*(NCH+1); i++) begin
      @(posedge clk28);
      #1;
      if (sample_strobe) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic count_ones(input int n, output int cl, output int cr);
    cl = 0;
    cr = 0;
    repeat (n) begin
      @(negedge clk28);
      cl += int'(dac_l);
      cr += int'(dac_r);
    end
  endtask

  task automatic apply_check(input string tag);
    drive();
    wait_strobe();
    chk({tag, "_l"}, sample_l, expect_side(0));
    chk({tag, "_r"}, sample_r, expect_side(1));
  endtask

  task automatic density(input string tag);
    int cl, cr;
    repeat (3) @(negedge clk28);
    count_ones(1 << OUT_W, cl, cr);
    chk({tag, "_dens_l"}, cl, expect_side(0));
    chk({tag, "_dens_r"}, cr, expect_side(1));
    wait_strobe();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cl, cr;
    set_all(0, 0, 0);
    drive();

    repeat (3) @(negedge clk28);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_sample_l", sample_l, 0);
    chk("rst_sample_r", sample_r, 0);
    chk("rst_dac_l", dac_l, 0);
    chk("rst_dac_r", dac_r, 0);

    rst_n = 1'b1;
    edges_to_strobe(n);
    chk("first_strobe_edge", n, NCH + 1);
    edges_to_strobe(n);
    chk("strobe_period", n, NCH + 1);
    chk("idle_sample_l", sample_l, 0);
    chk("idle_sample_r", sample_r, 0);
    count_ones(300, cl, cr);
    chk("idle_dac_l", cl, 0);
    chk("idle_dac_r", cr, 0);
    wait_strobe();

    set_all(0, 0, 0);
    data_m[0] = 255; gain_m[0] = 3; pan_m[0] = 3;
    apply_check("ch0_full");
    density("ch0_full");

    set_all(0, 0, 0);
    data_m[1] = 128; gain_m[1] = 3; pan_m[1] = 1;
    apply_check("ch1_left");
    density("ch1_left");
    gain_m[1] = 1;
    apply_check("ch1_gain1");
    gain_m[1] = 0;
    apply_check("ch1_gain0");

    set_all(0, 0, 0);
    beep_m = 1; tout_m = 1; tin_m = 1;
    apply_check("fixed_lvls");

    set_all(255, 3, 3);
    beep_m = 1;
    apply_check("clamp");
    density("clamp");

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < NCH; i++) begin
        data_m[i] = int'($urandom_range(0, 255));
        gain_m[i] = int'($urandom_range(0, 3));
        pan_m[i]  = int'($urandom_range(0, 3));
      end
      beep_m = 1'($urandom_range(0, 1));
      tout_m = 1'($urandom_range(0, 1));
      tin_m  = 1'($urandom_range(0, 1));
      mute_m = ($urandom_range(0, 7) == 0);
      apply_check("rand");
      if (k % 8 == 3) density("rand");
    end

    set_all(16, 3, 3);
    apply_check("ch_all16");
    @(negedge clk28);
    @(negedge clk28);
    mute = 1'b1;
    @(negedge clk28);
    mute = 1'b0;
    wait_strobe();
    chk("mute_slot2_l", sample_l, expect_side(0) - contrib(2));
    chk("mute_slot2_r", sample_r, expect_side(1) - contrib(2));

    @(negedge clk28);
    @(negedge clk28);
    rst_n = 1'b0;
    @(negedge clk28);
    chk("midrst_sample_l", sample_l, 0);
    chk("midrst_sample_r", sample_r, 0);
    chk("midrst_strobe", sample_strobe, 0);
    rst_n = 1'b1;
    edges_to_strobe(n);
    chk("midrst_strobe_edge", n, NCH + 1);
    chk("midrst_frame_l", sample_l, expect_side(0));
    chk("midrst_frame_r", sample_r, expect_side(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
